// File: rtl/adder_pkg.sv
// Shared adder definitions: FSM state type and default operand width.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// Existing one-bit full adder cell, used as the bit-slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder slice, registered carry,
// LSB-first over WIDTH cycles, with a start/busy/done handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state, datapath shifting and result publication.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = fa_cout;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        // count holds the index of the bit being added this edge; the
        // last bit completes the result and count stays at WIDTH-1.
        if (count_q == LAST) begin
          state_d = DONE;
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, hand-written
// corner sequences and randomized operations against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Called #1 after a posedge; the next posedge is the accept edge E0.
  task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    start = 1'b1;
    a     = xa;
    b     = xb;
    cin   = xc;
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Starts #1 after E0; returns at the sample where done is high (dk = edges after E0).
  task automatic wait_result(input int glitch_at, output logic [W-1:0] s, output logic c,
                             output int nbusy, output int dk, output bit stable);
    logic [W-1:0] ps;
    logic         pc;
    ps = sum;
    pc = cout;
    stable = 1'b1;
    nbusy = 0;
    dk = -1;
    for (int k = 0; k < 30; k++) begin
      if (k == glitch_at) begin
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
      end else if (k == glitch_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        dk = k;
        break;
      end
      if (busy) nbusy++;
      if (sum !== ps || cout !== pc) stable = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    s = sum;
    c = cout;
    if (dk < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout waiting for done got=none exp=done at %0t", $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [W-1:0] rs;
  logic         rc;
  int           nb, dk;
  bit           st;
  logic [W:0]   model;
  logic [W-1:0] ra, rb;
  logic         rcin;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum",  64'(sum),  64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors, each started from IDLE.
    foreach (vecs[i]) begin
      launch(vecs[i].va, vecs[i].vb, vecs[i].vcin);
      check("busy_after_accept", 64'(busy), 64'd1);
      wait_result(-1, rs, rc, nb, dk, st);
      check("vec_sum",   64'(rs), 64'(vecs[i].esum));
      check("vec_cout",  64'(rc), 64'(vecs[i].ecout));
      check("vec_busy_cycles", 64'(nb), 64'd8);
      check("vec_done_latency", 64'(dk), 64'd8);
      check("vec_outputs_stable_while_busy", 64'(st), 64'd1);
      check("done_busy_low", 64'(busy), 64'd0);
      step(1);
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Start while busy is ignored.
    launch(8'h10, 8'h20, 1'b0);
    wait_result(2, rs, rc, nb, dk, st);
    check("ignore_sum",  64'(rs), 64'h30);
    check("ignore_cout", 64'(rc), 64'd0);
    check("ignore_latency", 64'(dk), 64'd8);
    step(1);
    check("ignore_no_restart_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 10; i++) begin
      check("ignore_single_done", 64'(done), 64'd0);
      step(1);
    end

    // Back-to-back: start held during the done cycle.
    launch(8'h12, 8'h34, 1'b0);
    wait_result(-1, rs, rc, nb, dk, st);
    check("b2b_first_sum",  64'(rs), 64'h46);
    check("b2b_first_cout", 64'(rc), 64'd0);
    launch(8'h0F, 8'hF0, 1'b1);
    check("b2b_no_bubble", 64'(busy), 64'd1);
    check("b2b_prev_held", 64'(sum), 64'h46);
    wait_result(-1, rs, rc, nb, dk, st);
    check("b2b_second_sum",  64'(rs), 64'h00);
    check("b2b_second_cout", 64'(rc), 64'd1);
    check("b2b_second_latency", 64'(dk), 64'd8);
    step(1);

    // Reset mid-operation aborts without publishing.
    launch(8'hAA, 8'h55, 1'b0);
    step(3);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_done", 64'(done), 64'd0);
    check("mid_reset_sum",  64'(sum),  64'd0);
    check("mid_reset_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check("post_reset_no_done", 64'(done), 64'd0);
      step(1);
    end
    launch(8'h01, 8'h02, 1'b0);
    wait_result(-1, rs, rc, nb, dk, st);
    check("post_reset_sum",  64'(rs), 64'h03);
    check("post_reset_cout", 64'(rc), 64'd0);
    step(1);

    // Randomized operations with random idle gaps (0 gap = back-to-back).
    for (int n = 0; n < 2000; n++) begin
      ra    = W'($urandom);
      rb    = W'($urandom);
      rcin  = 1'($urandom);
      model = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rcin);
      launch(ra, rb, rcin);
      wait_result(((n % 3) == 0) ? int'($urandom_range(0, 6)) : -1, rs, rc, nb, dk, st);
      check("rand_result", 64'({rc, rs}), 64'(model));
      check("rand_latency", 64'(dk), 64'd8);
      step(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder
